// File: rtl/uart_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// uart_ctrl_pkg
// Shared types and constants for the UART transmit arbiter.
//   state_t    : arbiter FSM states
//   HDR_MAGIC  : upper nibble of the source-ID header byte
//   hdr_byte() : builds the header byte {HDR_MAGIC, id}
// ----------------------------------------------------------------------------
package uart_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HDR_START = 3'd1,
        HDR_WAIT  = 3'd2,
        DAT_START = 3'd3,
        DAT_WAIT  = 3'd4
    } state_t;

    localparam logic [3:0] HDR_MAGIC = 4'hA;

    function automatic logic [7:0] hdr_byte(input logic [3:0] id);
        return {HDR_MAGIC, id};
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first set request bit found by
// searching upward from i_ptr, wrapping at N. The caller owns the pointer.
// Ports:
//   i_req   [N-1:0]          request vector
//   i_ptr   [$clog2(N)-1:0]  index with highest priority this cycle
//   o_grant [N-1:0]          one-hot grant (zero when no request)
//   o_win   [$clog2(N)-1:0]  index of the granted request
//   o_any                    at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_grant,
    output logic [$clog2(N)-1:0] o_win,
    output logic                 o_any
);
    localparam int W = $clog2(N);

    logic [W-1:0] w_idx;

    always_comb begin
        o_grant = '0;
        o_win   = '0;
        w_idx   = '0;
        o_any   = |i_req;
        // Walk from the farthest offset down to offset 0 so the closest
        // requester to the pointer is the last (winning) assignment.
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = W'((int'(i_ptr) + k) % N);
            if (i_req[w_idx]) begin
                o_win = w_idx;
            end
        end
        if (o_any) begin
            o_grant[o_win] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter among NUM_REQ byte producers. Round-robin
// arbitration, optional source-ID header byte, start/done sequencing with
// the tx core, and a watchdog that aborts a transfer whose done never comes.
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_req_valid/_data    per-requester byte offer (data at [i*DATA_W +: DATA_W])
//   o_req_ready          one-cycle accept pulse, at most one bit set
//   o_uart_start         one-cycle start pulse to the tx core
//   o_uart_data          byte to the tx core, stable from start until done
//   i_uart_done          one-cycle frame-complete pulse from the tx core
//   o_grant_id           requester currently being served
//   o_busy               FSM is not idle
//   o_err_timeout        one-cycle watchdog abort pulse
// ----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int HDR_EN      = 1,
    parameter int TIMEOUT_CYC = 131072
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  i_req_data,
    output logic [NUM_REQ-1:0]         o_req_ready,
    output logic                       o_uart_start,
    output logic [DATA_W-1:0]          o_uart_data,
    input  logic                       i_uart_done,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
    output logic                       o_busy,
    output logic                       o_err_timeout
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int WD_W = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [ID_W-1:0] ID_LAST = ID_W'(NUM_REQ - 1);

    state_t            r_state;
    state_t            w_next;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_grant_id;
    logic [DATA_W-1:0] r_byte_q;
    logic [DATA_W-1:0] r_uart_data;
    logic [WD_W-1:0]   r_wd;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_win;
    logic               w_any;
    logic               w_accept;
    logic               w_wd_expire;
    logic [DATA_W-1:0]  w_win_data;
    logic [DATA_W-1:0]  w_win_hdr;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .i_req   (i_req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_win   (w_win),
        .o_any   (w_any)
    );

    assign w_win_data  = i_req_data[w_win*DATA_W +: DATA_W];
    assign w_win_hdr   = DATA_W'(hdr_byte(4'(w_win)));
    assign w_wd_expire = (r_wd == WD_LAST);

    // Next state and handshake outputs. Done wins over watchdog expiry in
    // the same cycle, so a late-but-arrived frame is never reported as an error.
    always_comb begin
        w_next        = r_state;
        o_req_ready   = '0;
        o_uart_start  = 1'b0;
        o_err_timeout = 1'b0;
        w_accept      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_accept    = 1'b1;
                    o_req_ready = w_grant;
                    w_next      = (HDR_EN != 0) ? HDR_START : DAT_START;
                end
            end
            HDR_START: begin
                o_uart_start = 1'b1;
                w_next       = HDR_WAIT;
            end
            HDR_WAIT: begin
                if (i_uart_done) begin
                    w_next = DAT_START;
                end else if (w_wd_expire) begin
                    o_err_timeout = 1'b1;
                    w_next        = IDLE;
                end
            end
            DAT_START: begin
                o_uart_start = 1'b1;
                w_next       = DAT_WAIT;
            end
            DAT_WAIT: begin
                if (i_uart_done) begin
                    w_next = IDLE;
                end else if (w_wd_expire) begin
                    o_err_timeout = 1'b1;
                    w_next        = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
        // Reset silences every pulse output in the reset cycle itself.
        if (i_rst) begin
            o_req_ready   = '0;
            o_uart_start  = 1'b0;
            o_err_timeout = 1'b0;
            w_accept      = 1'b0;
            w_next        = IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_grant_id  <= '0;
            r_byte_q    <= '0;
            r_uart_data <= '0;
            r_wd        <= '0;
        end else begin
            r_state <= w_next;

            if (w_accept) begin
                r_byte_q    <= w_win_data;
                r_grant_id  <= w_win;
                r_rr_ptr    <= (w_win == ID_LAST) ? '0 : w_win + 1'b1;
                r_uart_data <= (HDR_EN != 0) ? w_win_hdr : w_win_data;
            end else if (r_state == HDR_WAIT && i_uart_done) begin
                r_uart_data <= r_byte_q;
            end

            // Watchdog: zeroed as a WAIT state is entered, then counts WAIT cycles.
            if (r_state == HDR_START || r_state == DAT_START) begin
                r_wd <= '0;
            end else if (r_state == HDR_WAIT || r_state == DAT_WAIT) begin
                r_wd <= r_wd + 1'b1;
            end
        end
    end

    assign o_busy      = (r_state != IDLE);
    assign o_grant_id  = r_grant_id;
    assign o_uart_data = r_uart_data;

endmodule
